// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the memory-stage access controller: FSM encodings,
// bus geometry and the misalignment rule.
package dmem_access_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef logic [1:0] state_t;

    // Only word accesses have an alignment requirement; bytes may sit in any lane.
    function automatic logic is_misaligned(input logic byte_op, input logic [1:0] lane);
        return !byte_op && (lane != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus: registered request side from the access unit, one-cycle
// ack pulse with read data from the memory.
interface dmem_access_unit_if;
    import dmem_access_unit_pkg::*;

    logic                  bus_req;
    logic                  bus_we;
    logic [DATA_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/dmem_access_unit_byte_lane.sv
// Combinational byte-lane steering: enables, store replication and
// zero-extended load extraction for byte accesses; pass-through for words.
module dmem_access_unit_byte_lane #(
    parameter int DW = 32,
    parameter int LW = $clog2(DW / 8)
) (
    input  logic              byte_op,
    input  logic [LW-1:0]     lane,
    input  logic [DW-1:0]     wdata_in,
    input  logic [DW-1:0]     rdata_in,
    output logic [DW/8-1:0]   be,
    output logic [DW-1:0]     wdata_out,
    output logic [DW-1:0]     rdata_out
);

    logic [DW-1:0] rdata_shifted;

    assign rdata_shifted = rdata_in >> (8 * lane);

    always_comb begin
        be        = '1;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        if (byte_op) begin
            be        = (DW/8)'(1) << lane;
            wdata_out = {(DW/8){wdata_in[7:0]}};
            rdata_out = {{(DW-8){1'b0}}, rdata_shifted[7:0]};
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage access controller: turns each M-stage load/store into one bus
// transaction and stalls the pipeline until it completes, faults or times out.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic                    ByteM,
    input  logic [DATA_W-1:0]       ALUOutM,
    input  logic [DATA_W-1:0]       WriteDataM,
    output logic [DATA_W-1:0]       ReadData,
    output logic                    MemStall,
    output logic                    MemFault,
    dmem_access_unit_if.master      bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic                byte_q;
    logic [1:0]          lane_q;

    logic                mem_op;
    logic                byte_sel;
    logic [1:0]          lane_sel;
    logic [DATA_W/8-1:0] lane_be;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   lane_rdata;

    assign mem_op = MemReadM | MemWriteM;

    // One lane unit serves both phases: M-stage inputs while issuing, the
    // latched lane while waiting for read data.
    assign byte_sel = (state == S_ACCESS) ? byte_q : ByteM;
    assign lane_sel = (state == S_ACCESS) ? lane_q : ALUOutM[1:0];

    dmem_access_unit_byte_lane #(
        .DW (DATA_W)
    ) u_byte_lane (
        .byte_op   (byte_sel),
        .lane      (lane_sel),
        .wdata_in  (WriteDataM),
        .rdata_in  (bus.bus_rdata),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    always_comb begin
        MemStall = 1'b0;
        case (state)
            S_IDLE:   MemStall = mem_op;
            S_ACCESS: MemStall = 1'b1;
            default:  MemStall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            byte_q        <= 1'b0;
            lane_q        <= 2'b00;
            ReadData      <= '0;
            MemFault      <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        if (is_misaligned(ByteM, ALUOutM[1:0])) begin
                            MemFault <= 1'b1;
                            ReadData <= '0;
                            state    <= S_DONE;
                        end else begin
                            // A simultaneous read and write request is issued as a write.
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= MemWriteM;
                            bus.bus_addr  <= {ALUOutM[DATA_W-1:2], 2'b00};
                            bus.bus_wdata <= lane_wdata;
                            bus.bus_be    <= lane_be;
                            byte_q        <= ByteM;
                            lane_q        <= ALUOutM[1:0];
                            count         <= '0;
                            state         <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack arriving in the final allowed cycle still completes normally.
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            ReadData <= lane_rdata;
                        end
                        state <= S_DONE;
                    end else if (count == TO_LAST) begin
                        bus.bus_req <= 1'b0;
                        ReadData    <= '0;
                        MemFault    <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench: hand-derived vector table, randomized transactions
// against a transaction-level model, and a mid-access reset sequence.
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, ByteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadData;
    logic        MemStall, MemFault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_rd;
    logic        model_fault;

    dmem_access_unit_if bus ();

    dmem_access_unit #(
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .MemStall   (MemStall),
        .MemFault   (MemFault),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ack_at: ACCESS cycle (1-based) in which memory acks; 0 means never.
    typedef struct {
        logic        rd, wr, byt;
        logic [31:0] addr, wdata, rdata;
        int          ack_at;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_stall, exp_acc;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr, exp_wdata;
    } vec_t;

    function automatic vec_t dirVec(
        input logic rd, input logic wr, input logic byt,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
        input int ack_at, input logic [31:0] exp_data, input logic exp_fault,
        input int exp_stall, input int exp_acc, input logic [3:0] exp_be,
        input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.byt = byt;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at;
        v.exp_data = exp_data; v.exp_fault = exp_fault;
        v.exp_stall = exp_stall; v.exp_acc = exp_acc;
        v.exp_we = wr; v.exp_be = exp_be;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Transaction-level reference: outcome of one M-stage instruction.
    task automatic buildExpect(inout vec_t v);
        int lane;
        lane        = int'(v.addr[1:0]);
        v.exp_we    = v.wr;
        v.exp_addr  = v.addr & 32'hFFFF_FFFC;
        v.exp_be    = v.byt ? 4'(1 << lane) : 4'hF;
        v.exp_wdata = v.byt ? v.wdata[7:0] * 32'h0101_0101 : v.wdata;
        if (!(v.rd || v.wr)) begin
            v.exp_stall = 0; v.exp_acc = 0;
        end else if (!v.byt && lane != 0) begin
            v.exp_stall = 1; v.exp_acc = 0;
            model_fault = 1'b1; model_rd = 32'h0;
        end else if (v.ack_at >= 1 && v.ack_at <= TO) begin
            v.exp_acc = v.ack_at; v.exp_stall = v.ack_at + 1;
            if (!v.wr) model_rd = v.byt ? (v.rdata >> (8 * lane)) & 32'hFF : v.rdata;
        end else begin
            v.exp_acc = TO; v.exp_stall = TO + 1;
            model_fault = 1'b1; model_rd = 32'h0;
        end
        v.exp_data  = model_rd;
        v.exp_fault = model_fault;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Drives one instruction from IDLE through its release cycle, acting as memory.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          stall, acc;
        logic        done, stable;
        logic [31:0] a_addr, a_wdata;
        logic [3:0]  a_be;
        logic        a_we;
        stall = 0; acc = 0; done = 1'b0; stable = 1'b1;
        a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0;
        MemReadM = v.rd; MemWriteM = v.wr; ByteM = v.byt;
        ALUOutM = v.addr; WriteDataM = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (!MemStall) begin
                done = 1'b1;
            end else begin
                stall++;
                if (bus.bus_req) begin
                    acc++;
                    if (acc == 1) begin
                        a_addr = bus.bus_addr; a_wdata = bus.bus_wdata;
                        a_be = bus.bus_be; a_we = bus.bus_we;
                    end else if (bus.bus_addr !== a_addr || bus.bus_wdata !== a_wdata ||
                                 bus.bus_be !== a_be || bus.bus_we !== a_we) begin
                        stable = 1'b0;
                    end
                    if (acc == v.ack_at) begin
                        bus.bus_ack = 1'b1; bus.bus_rdata = v.rdata;
                    end
                end
                @(negedge clk);
                bus.bus_ack = 1'b0; bus.bus_rdata = $urandom();
            end
        end
        checkOutput({tag, "_completes"}, 32'(done), 32'd1);
        checkOutput({tag, "_stall_cycles"}, 32'(stall), 32'(v.exp_stall));
        checkOutput({tag, "_access_cycles"}, 32'(acc), 32'(v.exp_acc));
        checkOutput({tag, "_ReadData"}, ReadData, v.exp_data);
        checkOutput({tag, "_MemFault"}, 32'(MemFault), 32'(v.exp_fault));
        checkOutput({tag, "_req_dropped"}, 32'(bus.bus_req), 32'd0);
        if (v.exp_acc > 0) begin
            checkOutput({tag, "_bus_addr"}, a_addr, v.exp_addr);
            checkOutput({tag, "_bus_be"}, 32'(a_be), 32'(v.exp_be));
            checkOutput({tag, "_bus_we"}, 32'(a_we), 32'(v.exp_we));
            checkOutput({tag, "_bus_stable"}, 32'(stable), 32'd1);
            if (v.wr) checkOutput({tag, "_bus_wdata"}, a_wdata, v.exp_wdata);
        end
        // Instruction leaves M; a stray ack here must be ignored.
        MemReadM = 1'b0; MemWriteM = 1'b0;
        bus.bus_ack = 1'($urandom_range(0, 1)); bus.bus_rdata = $urandom();
        @(negedge clk);
        bus.bus_ack = 1'b0;
    endtask

    vec_t table_v[10];

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
        ALUOutM = '0; WriteDataM = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_bus_req", 32'(bus.bus_req), 32'd0);
        checkOutput("reset_bus_we", 32'(bus.bus_we), 32'd0);
        checkOutput("reset_bus_be", 32'(bus.bus_be), 32'd0);
        checkOutput("reset_bus_addr", bus.bus_addr, 32'd0);
        checkOutput("reset_bus_wdata", bus.bus_wdata, 32'd0);
        checkOutput("reset_ReadData", ReadData, 32'd0);
        checkOutput("reset_MemFault", 32'(MemFault), 32'd0);
        checkOutput("reset_MemStall", 32'(MemStall), 32'd0);
        reset = 1'b0;

        //                 rd  wr  byt addr        wdata         rdata         ack exp_data      flt st acc be    exp_addr      exp_wdata
        table_v[0] = dirVec(1, 0, 0, 32'h100,  32'h0,         32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 2, 1, 4'hF, 32'h100,  32'h0);
        table_v[1] = dirVec(0, 1, 1, 32'h203,  32'h12345678,  32'h0,        3, 32'hDEADBEEF, 0, 4, 3, 4'h8, 32'h200,  32'h78787878);
        table_v[2] = dirVec(1, 0, 1, 32'h41,   32'h0,         32'hAABBCCDD, 1, 32'h000000CC, 0, 2, 1, 4'h2, 32'h40,   32'h0);
        table_v[3] = dirVec(1, 1, 0, 32'h300,  32'hCAFEF00D,  32'h0,        2, 32'h000000CC, 0, 3, 2, 4'hF, 32'h300,  32'hCAFEF00D);
        table_v[4] = dirVec(1, 0, 0, 32'h10,   32'h0,         32'h11223344, 4, 32'h11223344, 0, 5, 4, 4'hF, 32'h10,   32'h0);
        table_v[5] = dirVec(0, 0, 0, 32'h55,   32'h0,         32'h0,        1, 32'h11223344, 0, 0, 0, 4'hF, 32'h54,   32'h0);
        table_v[6] = dirVec(1, 0, 0, 32'h102,  32'h0,         32'h0,        1, 32'h0,        1, 1, 0, 4'hF, 32'h100,  32'h0);
        table_v[7] = dirVec(1, 0, 0, 32'h20,   32'h0,         32'h0,        0, 32'h0,        1, 5, 4, 4'hF, 32'h20,   32'h0);
        table_v[8] = dirVec(1, 0, 1, 32'h43,   32'h0,         32'h89ABCDEF, 2, 32'h00000089, 1, 3, 2, 4'h8, 32'h40,   32'h0);
        table_v[9] = dirVec(0, 1, 1, 32'h1002, 32'h000000A5,  32'h0,        1, 32'h00000089, 1, 2, 1, 4'h4, 32'h1000, 32'hA5A5A5A5);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i], $sformatf("vec%0d", i));
            model_rd    = table_v[i].exp_data;
            model_fault = table_v[i].exp_fault;
        end

        for (int i = 0; i < 60; i++) begin
            v.rd     = 1'($urandom_range(0, 1));
            v.wr     = 1'($urandom_range(0, 2) == 0);
            v.byt    = 1'($urandom_range(0, 1));
            v.addr   = $urandom();
            if (!v.byt && $urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata  = $urandom();
            v.rdata  = $urandom();
            v.ack_at = int'($urandom_range(0, TO + 1));
            buildExpect(v);
            applyStimulus(v, $sformatf("rnd%0d", i));
        end

        // Reset while the second ACCESS cycle is in progress, then a late ack.
        MemReadM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; ALUOutM = 32'h80;
        @(negedge clk);
        #1;
        checkOutput("rstseq_req_issued", 32'(bus.bus_req), 32'd1);
        @(negedge clk);
        reset = 1'b1; MemReadM = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstseq_bus_req", 32'(bus.bus_req), 32'd0);
        checkOutput("rstseq_MemStall", 32'(MemStall), 32'd0);
        checkOutput("rstseq_MemFault", 32'(MemFault), 32'd0);
        checkOutput("rstseq_ReadData", ReadData, 32'd0);
        reset = 1'b0;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h55555555;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        checkOutput("rstseq_late_ack_ReadData", ReadData, 32'd0);
        checkOutput("rstseq_late_ack_MemStall", 32'(MemStall), 32'd0);
        checkOutput("rstseq_late_ack_bus_req", 32'(bus.bus_req), 32'd0);
        @(negedge clk);

        model_rd = 32'h0; model_fault = 1'b0;
        v.rd = 1'b1; v.wr = 1'b0; v.byt = 1'b0; v.addr = 32'h44;
        v.wdata = 32'h0; v.rdata = 32'h0BADCAFE; v.ack_at = 2;
        buildExpect(v);
        applyStimulus(v, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
